// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-step add/sub, WIDTH-cycle shift-add multiply and restoring divide.
// Results and flags are registered and change only when an operation completes.
module alu_seq_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       ALUOp,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic [3:0]       flags
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] res_q, res_hi_q;
   logic [3:0]       flags_q;
   logic [WIDTH-1:0] work_hi_q, work_lo_q, opb_q;
   logic [WIDTH-1:0] work_hi_d, work_lo_d;
   logic [1:0]       kind;
   logic             accept;
   logic [WIDTH:0]   add_full, msum, rshift;
   logic [WIDTH-1:0] sub_res, rdiff;

   function automatic logic [3:0] make_flags(input logic dz, input logic carry,
                                             input logic [WIDTH-1:0] r);
      return {dz, carry, r[WIDTH-1], (r == '0)};
   endfunction

   assign ready     = (state_q == S_IDLE) || (state_q == S_DONE);
   assign done      = (state_q == S_DONE);
   assign accept    = start && ready;
   // kind encoding matches op: 00 add, 01 sub, 10 mul, 11 div
   assign kind      = (ALUOp == 2'b10) ? op : {1'b0, (ALUOp == 2'b01)};
   assign add_full  = {1'b0, a} + {1'b0, b};
   assign sub_res   = a - b;
   assign result    = res_q;
   assign result_hi = res_hi_q;
   assign flags     = flags_q;

   // One iteration step: work_hi is the partial product / remainder, work_lo the multiplier / quotient.
   always_comb begin
      work_hi_d = work_hi_q;
      work_lo_d = work_lo_q;
      msum      = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opb_q} : '0);
      rshift    = {work_hi_q, work_lo_q[WIDTH-1]};
      rdiff     = rshift[WIDTH-1:0] - opb_q;
      if (state_q == S_MUL) begin
         {work_hi_d, work_lo_d} = {msum, work_lo_q[WIDTH-1:1]};
      end else if (rshift >= {1'b0, opb_q}) begin
         work_hi_d = rdiff;
         work_lo_d = {work_lo_q[WIDTH-2:0], 1'b1};
      end else begin
         work_hi_d = rshift[WIDTH-1:0];
         work_lo_d = {work_lo_q[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         work_hi_q <= '0;
         work_lo_q <= a;
         opb_q     <= b;
      end else if (state_q == S_MUL || state_q == S_DIV) begin
         work_hi_q <= work_hi_d;
         work_lo_q <= work_lo_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         res_q    <= '0;
         res_hi_q <= '0;
         flags_q  <= '0;
      end else if (accept) begin
         cnt_q <= CW'(WIDTH);
         case (kind)
            2'b00: begin
               res_q    <= add_full[WIDTH-1:0];
               res_hi_q <= '0;
               flags_q  <= make_flags(1'b0, add_full[WIDTH], add_full[WIDTH-1:0]);
               state_q  <= S_DONE;
            end
            2'b01: begin
               res_q    <= sub_res;
               res_hi_q <= '0;
               flags_q  <= make_flags(1'b0, (a >= b), sub_res);
               state_q  <= S_DONE;
            end
            2'b10: state_q <= S_MUL;
            default: begin
               if (b == '0) begin
                  res_q    <= '1;
                  res_hi_q <= a;
                  flags_q  <= make_flags(1'b1, 1'b0, '1);
                  state_q  <= S_DONE;
               end else begin
                  state_q <= S_DIV;
               end
            end
         endcase
      end else begin
         case (state_q)
            S_MUL, S_DIV: begin
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  res_q    <= work_lo_d;
                  res_hi_q <= work_hi_d;
                  flags_q  <= make_flags(1'b0, (state_q == S_MUL) && (work_hi_d != '0), work_lo_d);
                  state_q  <= S_DONE;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit (WIDTH=8): directed cases, reset abort, then random traffic.
module tb_alu_seq_unit;

   localparam int W = 8;
   localparam int M = 1 << W;

   logic         clk = 1'b0;
   logic         rst_n, start, ready, done;
   logic [1:0]   ALUOp, op;
   logic [W-1:0] a, b, result, result_hi;
   logic [3:0]   flags;

   typedef struct {
      int res;
      int hi;
      int fl;
      int cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_res = 0, last_hi = 0, last_fl = 0;

   alu_seq_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ALUOp(ALUOp), .op(op),
      .a(a), .b(b), .ready(ready), .done(done), .result(result),
      .result_hi(result_hi), .flags(flags)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Reference behaviour written straight from the arithmetic rules.
   function automatic exp_t model(input int ao, input int o, input int aa, input int bb, input int now);
      exp_t e;
      int   k, r, h, c, dz, lat;
      longint p;
      k = (ao == 2) ? o : ((ao == 1) ? 1 : 0);
      r = 0; h = 0; c = 0; dz = 0; lat = 0;
      case (k)
         0: begin r = (aa + bb) % M; c = ((aa + bb) >= M) ? 1 : 0; end
         1: begin r = (aa - bb + M) % M; c = (aa >= bb) ? 1 : 0; end
         2: begin p = longint'(aa) * bb; r = int'(p % M); h = int'(p / M); c = (h != 0) ? 1 : 0; lat = W; end
         default: begin
            if (bb == 0) begin r = M - 1; h = aa; dz = 1; end
            else begin r = aa / bb; h = aa % bb; lat = W; end
         end
      endcase
      e.res = r;
      e.hi  = h;
      e.fl  = dz * 8 + c * 4 + ((r >= M / 2) ? 2 : 0) + ((r == 0) ? 1 : 0);
      e.cyc = now + 1 + lat;
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         last_res = 0; last_hi = 0; last_fl = 0;
      end else if (done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check("result", longint'(result), mon_e.res);
            check("result_hi", longint'(result_hi), mon_e.hi);
            check("flags", longint'(flags), mon_e.fl);
            check("done_cycle", cyc, mon_e.cyc);
            last_res = mon_e.res; last_hi = mon_e.hi; last_fl = mon_e.fl;
         end
      end else begin
         check("hold_outputs", {40'd0, result, result_hi, flags, 4'd0},
               {40'd0, 8'(last_res), 8'(last_hi), 4'(last_fl), 4'd0});
      end
   end

   task automatic issue(input logic [1:0] ao, input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
      int n = 0;
      @(negedge clk);
      while (!ready && n < 100) begin
         start = 1'($urandom);
         ALUOp = 2'($urandom); op = 2'($urandom);
         a = W'($urandom); b = W'($urandom);
         n++;
         @(negedge clk);
      end
      if (!ready) check("ready_timeout", 0, 1);
      ALUOp = ao; op = o; a = aa; b = bb; start = 1'b1;
      sb.push_back(model(int'(ao), int'(o), int'(aa), int'(bb), cyc));
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      start = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, longint'(ready), 1);
      check({tag, "_done"}, longint'(done), 0);
      check({tag, "_result"}, longint'(result), 0);
      check({tag, "_result_hi"}, longint'(result_hi), 0);
      check({tag, "_flags"}, longint'(flags), 0);
   endtask

   initial begin
      int n;
      logic [1:0] rao, rop;
      logic [W-1:0] ra, rb;
      rst_n = 1'b0; start = 1'b0; ALUOp = '0; op = '0; a = '0; b = '0;
      #1 check_reset_outputs("por");
      @(negedge clk); @(negedge clk);
      #2 rst_n = 1'b1;

      // Directed arithmetic cases, the first three back to back
      issue(2'b00, 2'b00, 8'd200, 8'd100);
      issue(2'b01, 2'b00, 8'd5, 8'd5);
      issue(2'b01, 2'b00, 8'd3, 8'd5);
      idle(2);
      issue(2'b10, 2'b10, 8'd255, 8'd255);
      idle(1);
      issue(2'b10, 2'b11, 8'd100, 8'd7);
      issue(2'b10, 2'b11, 8'd100, 8'd0);
      issue(2'b11, 2'b10, 8'd9, 8'd250);
      idle(3);

      // Reset in the middle of a multiply, with a stray start pulse first
      issue(2'b10, 2'b10, 8'd37, 8'd91);
      @(negedge clk); start = 1'b1; ALUOp = 2'b00; a = 8'd1; b = 8'd1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("abort");
      sb.delete();
      @(negedge clk); @(negedge clk);
      #2 rst_n = 1'b1;
      ALUOp = 2'b00; op = 2'b00; a = 8'd17; b = 8'd25; start = 1'b1;
      sb.push_back(model(0, 0, 17, 25, cyc));
      idle(W + 3);

      for (int i = 0; i < 250; i++) begin
         rao = 2'($urandom); rop = 2'($urandom);
         ra = W'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         issue(rao, rop, ra, rb);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end

      idle(1);
      n = 0;
      while (sb.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", sb.size(), 0);
      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
